// File: rtl/mul_pkg.sv
// Shared types for the iterative multiplier: FSM state encoding and the
// iteration-counter width helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count iterations 0..w-1.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per BUSY cycle,
// signed or unsigned operands chosen per request.
//
// Ports:
//   mul_clk    - clock, all state changes on the rising edge
//   reset      - synchronous active-high reset
//   in_valid   - operand request valid
//   in_ready   - high in IDLE only
//   mul_signed - 1 = signed operands (sampled at input handshake)
//   x, y       - multiplicand / multiplier (sampled at input handshake)
//   out_valid  - high in DONE only
//   out_ready  - consumer accepts result
//   result     - 2*WIDTH product, held until the next product
//
// Build option: define MUL_ITER_EARLY_TERM_EN to end BUSY as soon as no
// multiplier bits remain to be processed.
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 mul_clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mul_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

    state_t          state;
    logic [PW-1:0]   acc;
    // Extended multiplicand, pre-shifted left by the current iteration.
    logic [PW-1:0]   xsh;
    // Multiplier shifted right so bit 0 is the bit of this iteration.
    logic [WIDTH-1:0] ysh;
    logic            ysign;
    logic [CW-1:0]   cnt;

    logic [WIDTH:0]  xe;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_next;
    logic            last;

    assign xe = {mul_signed & x[WIDTH-1], x};

    always_comb begin
        addend   = ysh[0] ? xsh : '0;
        acc_next = acc + addend;
        // Extended y sign bit carries weight -2^WIDTH.
        if (cnt == LAST_IT && ysign) begin
            acc_next = acc_next - (xsh << 1);
        end
    end

`ifdef MUL_ITER_EARLY_TERM_EN
    // Stop once nothing above the current bit can still contribute.
    always_comb begin
        last = (cnt == LAST_IT) ||
               (!ysign && (ysh[WIDTH-1:1] == '0));
    end
`else
    always_comb begin
        last = (cnt == LAST_IT);
    end
`endif

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            acc       <= '0;
            xsh       <= '0;
            ysh       <= '0;
            ysign     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        acc      <= '0;
                        cnt      <= '0;
                        xsh      <= {{(PW-WIDTH-1){xe[WIDTH]}}, xe};
                        ysh      <= y;
                        ysign    <= mul_signed & y[WIDTH-1];
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    xsh <= xsh << 1;
                    ysh <= ysh >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        result    <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter (WIDTH=32): directed corner products,
// latency, backpressure, mid-operation reset and random operands.
module tb_mul_iter;

    localparam int W = 32;

    logic          mul_clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          mul_signed;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] result;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] sb[$];

    always #5 mul_clk = ~mul_clk;

    mul_iter #(.WIDTH(W)) dut (
        .mul_clk    (mul_clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mul_signed (mul_signed),
        .x          (x),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    function automatic int exp_busy(input logic [31:0] b, input logic s);
`ifdef MUL_ITER_EARLY_TERM_EN
        if (s && b[31]) return W;
        for (int i = W - 1; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
`else
        return W + 0 * int'(b[0] ^ s);
`endif
    endfunction

    // One full transaction; hold>0 keeps out_ready low that many DONE cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold,
                          input string tag);
        int n;
        logic [63:0] got;
        n = 0;
        out_ready = 1'b0;
        while (!in_ready && n < 200) begin
            @(negedge mul_clk);
            n++;
        end
        x = a;
        y = b;
        mul_signed = s;
        in_valid = 1'b1;
        @(posedge mul_clk);
        sb.push_back(model(a, b, s));
        @(negedge mul_clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge mul_clk);
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(exp_busy(b, s) + 1));
        for (int k = 0; k < hold; k++) begin
            got = result;
            in_valid = 1'b1;
            x = $urandom;
            y = $urandom;
            @(negedge mul_clk);
            chk({tag, "_hold_res"}, 128'(result), 128'(got));
            chk({tag, "_hold_ov"}, 128'(out_valid), 128'(1));
            chk({tag, "_hold_ir"}, 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        got = result;
        if (sb.size() > 0) begin
            chk({tag, "_res"}, 128'(got), 128'(sb.pop_front()));
        end else begin
            chk({tag, "_sb_empty"}, 128'(1), 128'(0));
        end
        @(negedge mul_clk);
        out_ready = 1'b0;
        if (hold > 0) begin
            chk({tag, "_rel_ov"}, 128'(out_valid), 128'(0));
            chk({tag, "_rel_ir"}, 128'(in_ready), 128'(1));
            chk({tag, "_idle_res"}, 128'(result), 128'(got));
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        mul_signed = 1'b0;
        x = '0;
        y = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge mul_clk);
        chk("rst_ir", 128'(in_ready), 128'(1));
        chk("rst_ov", 128'(out_valid), 128'(0));
        chk("rst_res", 128'(result), 128'(0));
        reset = 1'b0;
        @(negedge mul_clk);

        run_op(32'd3, 32'd5, 1'b0, 0, "u3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "s_m1");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "u_max");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "s_min2");
        run_op(32'h8000_0000, 32'd1, 1'b1, 0, "s_minx1");
        run_op(32'd7, 32'd2, 1'b0, 0, "u7x2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "s7xm2");
        run_op(32'd0, 32'd0, 1'b0, 0, "zero");
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10, "bp");

        // Reset while iteration 7 is next.
        x = 32'hDEAD_BEEF;
        y = 32'h1357_9BDF;
        mul_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge mul_clk);
        @(negedge mul_clk);
        in_valid = 1'b0;
        repeat (7) @(negedge mul_clk);
        reset = 1'b1;
        @(negedge mul_clk);
        reset = 1'b0;
        chk("mid_rst_ir", 128'(in_ready), 128'(1));
        chk("mid_rst_ov", 128'(out_valid), 128'(0));
        chk("mid_rst_res", 128'(result), 128'(0));
        sb.delete();
        run_op(32'd6, 32'd7, 1'b0, 0, "after_rst");
        chk("after_rst_val", 128'(result), 128'h2A);

        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, "rand");
        end

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
